lg_shift_seq: RTL and testbench



---
 rtl/lg_shift_seq.sv | 117 +++++++++++
 tb/tb_lg_shift_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lg_shift_seq.sv
// rtl/lg_shift_seq.sv - Multi-bit SIMD logical shift sequencer around a single-step lane shifter.
// One lane-aware bit shift per clock; operand in and result out over valid/ready handshakes.

module lg_shifter (
    input  logic [15:0] din,
    input  logic        right,
    input  logic [1:0]  bitnum,
    output logic [15:0] dout
);
    logic [15:0] lane_mask;

    // Mask clears the bit that crossed into a neighbouring lane, giving zero fill per lane.
    always_comb begin
        lane_mask = 16'h0000;
        case (bitnum)
            2'b00:   lane_mask = right ? 16'h7777 : 16'hEEEE;
            2'b10:   lane_mask = right ? 16'h7FFF : 16'hFFFE;
            default: lane_mask = right ? 16'h7F7F : 16'hFEFE;
        endcase
    end

    assign dout = (right ? (din >> 1) : (din << 1)) & lane_mask;
endmodule

module lg_shift_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] datain,
    input  logic        right,
    input  logic [1:0]  bitnum,
    input  logic [3:0]  amount,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dataout,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        right_q, right_d;
    logic [1:0]  bitnum_q, bitnum_d;

    logic [15:0] shifted;
    logic [4:0]  lane_w;
    logic [4:0]  cnt_init;

    lg_shifter u_shifter (
        .din    (acc_q),
        .right  (right_q),
        .bitnum (bitnum_q),
        .dout   (shifted)
    );

    // Shifting a lane by its own width already zeroes it, so the count clamps there.
    always_comb begin
        lane_w = 5'd8;
        case (bitnum)
            2'b00:   lane_w = 5'd4;
            2'b10:   lane_w = 5'd16;
            default: lane_w = 5'd8;
        endcase
        cnt_init = ({1'b0, amount} > lane_w) ? lane_w : {1'b0, amount};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= 16'h0000;
            cnt_q    <= 5'd0;
            right_q  <= 1'b0;
            bitnum_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            right_q  <= right_d;
            bitnum_q <= bitnum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (cnt_init == 5'd0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (cnt_q == 5'd1) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        right_d  = right_q;
        bitnum_d = bitnum_q;
        if (state_q == S_IDLE && in_valid) begin
            acc_d    = datain;
            cnt_d    = cnt_init;
            right_d  = right;
            bitnum_d = bitnum;
        end else if (state_q == S_SHIFT) begin
            acc_d = shifted;
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        dataout   = acc_q;
    end
endmodule

// File: tb/tb_lg_shift_seq.sv
// tb/tb_lg_shift_seq.sv - Directed and random checks of lg_shift_seq against a per-lane arithmetic model.

module tb_lg_shift_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] datain;
    logic        right;
    logic [1:0]  bitnum;
    logic [3:0]  amount;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dataout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lg_shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .right     (right),
        .bitnum    (bitnum),
        .amount    (amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .busy      (busy)
    );

    function automatic int lane_width(input logic [1:0] b);
        if (b == 2'b00) return 4;
        if (b == 2'b10) return 16;
        return 8;
    endfunction

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic r,
                                              input logic [1:0] b, input int a);
        int w;
        int mask;
        int v;
        int res;
        w    = lane_width(b);
        mask = (1 << w) - 1;
        res  = 0;
        for (int l = 0; l < 16 / w; l++) begin
            v = (int'(d) >> (l * w)) & mask;
            if (a >= w) v = 0;
            else if (r) v = v >> a;
            else        v = (v << a) & mask;
            res = res | (v << (l * w));
        end
        return res[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, hold it for 'stall' cycles, then drain it.
    task automatic run_req(input string tag, input logic [15:0] d, input logic r,
                           input logic [1:0] b, input logic [3:0] a, input int stall);
        int lat;
        int exp_lat;
        logic [15:0] exp_d;
        exp_lat = (int'(a) > lane_width(b)) ? lane_width(b) : int'(a);
        exp_d   = ref_shift(d, r, b, int'(a));
        chk({tag, "_in_ready_pre"}, in_ready, 1);
        datain = d; right = r; bitnum = b; amount = a; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        datain = 16'($urandom); right = 1'($urandom); bitnum = 2'($urandom); amount = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) chk({tag, "_in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_dataout"}, dataout, exp_d);
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_data"}, dataout, exp_d);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, out_valid, 0);
        chk({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [15:0] held;
        int seen_valid;
        rst_n = 1'b0; in_valid = 1'b0; datain = 16'h0; right = 1'b0;
        bitnum = 2'b00; amount = 4'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dataout", dataout, 16'h0000);
        rst_n = 1'b1;

        run_req("t1", 16'h8001, 1'b1, 2'b10, 4'd3, 0);
        chk("t1_const", ref_shift(16'h8001, 1'b1, 2'b10, 3), 16'h1000);
        run_req("t2a", 16'hFFFF, 1'b0, 2'b00, 4'd1, 1);
        run_req("t2b", 16'h8888, 1'b1, 2'b00, 4'd2, 0);
        run_req("t3a", 16'h8080, 1'b1, 2'b01, 4'd9, 0);
        run_req("t3b", 16'h8080, 1'b1, 2'b11, 4'd9, 2);
        run_req("t4", 16'h1234, 1'b0, 2'b00, 4'd0, 0);

        // Backpressure while a new request waits on the input.
        datain = 16'h1234; right = 1'b1; bitnum = 2'b10; amount = 4'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        datain = 16'hFFFF; amount = 4'd0; bitnum = 2'b00;
        for (int i = 0; i < 10 && !out_valid; i++) begin @(posedge clk); #1; end
        held = dataout;
        chk("t5_data", held, ref_shift(16'h1234, 1'b1, 2'b10, 4));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_stable", dataout, held);
            chk("t5_in_ready", in_ready, 0);
            chk("t5_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_idle_ready", in_ready, 1);
        chk("t5_idle_busy", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_new_valid", out_valid, 1);
        chk("t5_new_data", dataout, 16'hFFFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a long shift.
        datain = 16'hABCD; right = 1'b0; bitnum = 2'b10; amount = 4'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen_valid = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_data", dataout, 16'h0000);
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        chk("t6_no_valid", seen_valid, 0);
        rst_n = 1'b1;
        run_req("t6_after", 16'h0F0F, 1'b0, 2'b10, 4'd5, 0);

        for (int k = 0; k < 24; k++) begin
            run_req("rnd", 16'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
